// File: rtl/uart_console_responder_if.sv
// Console port bundle between the core, the responder and the simulation host.
//   Core side : uart_out_valid/uart_out_ch (core -> TX FIFO),
//               uart_in_valid -> uart_in_ch (core read from RX FIFO)
//   Host side : host_tx_valid/ch/ready (TX FIFO drain),
//               host_rx_valid/ch/ready (RX FIFO fill)
//   Status    : tx_drop_cnt, rx_empty_cnt
// Modports: slave = responder, master = core/host models driving it.
interface uart_console_responder_if;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic        uart_in_valid;
  logic [7:0]  uart_in_ch;
  logic        host_tx_valid;
  logic [7:0]  host_tx_ch;
  logic        host_tx_ready;
  logic        host_rx_valid;
  logic [7:0]  host_rx_ch;
  logic        host_rx_ready;
  logic [15:0] tx_drop_cnt;
  logic [15:0] rx_empty_cnt;

  modport slave (
    input  uart_out_valid, uart_out_ch, uart_in_valid,
    input  host_tx_ready, host_rx_valid, host_rx_ch,
    output uart_in_ch, host_tx_valid, host_tx_ch, host_rx_ready,
    output tx_drop_cnt, rx_empty_cnt
  );

  modport master (
    output uart_out_valid, uart_out_ch, uart_in_valid,
    output host_tx_ready, host_rx_valid, host_rx_ch,
    input  uart_in_ch, host_tx_valid, host_tx_ch, host_rx_ready,
    input  tx_drop_cnt, rx_empty_cnt
  );
endinterface

// File: rtl/uart_console_responder.sv
// Console responder: buffers core output characters in a TX FIFO drained by
// the host (valid/ready) and serves core reads from an RX FIFO the host fills.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset, clears FIFOs and counters
//   bus   - uart_console_responder_if.slave (see interface file)
// Optional: define UART_CONSOLE_ECHO_EN to echo every character the core
// pops from the RX FIFO back into the TX FIFO (core output wins on conflict).
module uart_console_responder #(
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter logic [7:0]  EMPTY_CH = 8'hFF
) (
  input  logic clock,
  input  logic reset,
  uart_console_responder_if.slave bus
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [TAW:0] tx_wr_q, tx_rd_q;
  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [RAW:0] rx_wr_q, rx_rd_q;
  logic [15:0]  drop_q, drop_d, empty_q, empty_d;

  logic       tx_empty, tx_full, tx_pop, tx_req, tx_push, echo_req;
  logic       rx_empty, rx_full, rx_pop, rx_push;
  logic [7:0] tx_din, rx_head;
  logic [1:0] drop_inc;
  logic [16:0] drop_sum, empty_sum;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                    (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                    (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);

  assign rx_head = rx_mem_q[rx_rd_q[RAW-1:0]];
  assign rx_pop  = bus.uart_in_valid & ~rx_empty;
  // No bypass: a host push into an empty FIFO is only visible next cycle.
  assign rx_push = bus.host_rx_valid & ~rx_full;

`ifdef UART_CONSOLE_ECHO_EN
  assign echo_req = rx_pop;
`else
  assign echo_req = 1'b0;
`endif

  assign tx_req = bus.uart_out_valid | echo_req;
  assign tx_din = bus.uart_out_valid ? bus.uart_out_ch : rx_head;
  assign tx_pop = ~tx_empty & bus.host_tx_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign tx_push = tx_req & (~tx_full | tx_pop);

  // Up to two drops per cycle: echo losing to core output, plus the winner
  // itself being refused by a full FIFO.
  assign drop_inc = {1'b0, bus.uart_out_valid & echo_req} +
                    {1'b0, tx_req & ~tx_push};
  assign drop_sum  = {1'b0, drop_q} + {15'd0, drop_inc};
  assign empty_sum = {1'b0, empty_q} + {16'd0, bus.uart_in_valid & rx_empty};

  always_comb begin
    drop_d  = drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
    empty_d = empty_sum[16] ? 16'hFFFF : empty_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      drop_q  <= '0;
      empty_q <= '0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q[TAW-1:0]] <= tx_din;
        tx_wr_q <= tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) begin
        rx_mem_q[rx_wr_q[RAW-1:0]] <= bus.host_rx_ch;
        rx_wr_q <= rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      drop_q  <= drop_d;
      empty_q <= empty_d;
    end
  end

  assign bus.host_tx_valid = ~tx_empty;
  assign bus.host_tx_ch    = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[TAW-1:0]];
  assign bus.host_rx_ready = ~rx_full;
  assign bus.uart_in_ch    = rx_pop ? rx_head : EMPTY_CH;
  assign bus.tx_drop_cnt   = drop_q;
  assign bus.rx_empty_cnt  = empty_q;
endmodule

// File: tb/tb_uart_console_responder.sv
// Bench for uart_console_responder: a vector table for the basic traffic
// plus hand-written sequences for full/empty/reset corner cases.
module tb_uart_console_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_console_responder_if u_if();
  uart_console_responder #(.TX_DEPTH(16), .RX_DEPTH(16), .EMPTY_CH(8'hFF))
    dut (.clock(clock), .reset(reset), .bus(u_if.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    u_if.uart_out_valid = 1'b0;
    u_if.uart_out_ch    = 8'h00;
    u_if.uart_in_valid  = 1'b0;
    u_if.host_tx_ready  = 1'b0;
    u_if.host_rx_valid  = 1'b0;
    u_if.host_rx_ch     = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Inputs applied at a negedge; outputs checked 1ns later, i.e. the state
  // before the next rising edge plus the combinational uart_in_ch.
  typedef struct {
    logic       out_v;
    logic [7:0] out_ch;
    logic       in_v;
    logic       tx_rdy;
    logic       rx_v;
    logic [7:0] rx_ch;
    logic       chk_tx;
    logic       e_txv;
    logic [7:0] e_txch;
    logic       e_rxrdy;
    logic [7:0] e_inch;
    logic [15:0] e_drop;
    logic [15:0] e_empty;
  } vec_t;

  vec_t vec [11];

  initial begin
    //          out_v out_ch in_v rdy rx_v rx_ch chk txv txch  rxrdy inch drop empty
    vec[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[1]  = '{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[2]  = '{1'b1, 8'h69, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h69, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 16'd0, 16'd0};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h42, 16'd0, 16'd0};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd0};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 16'd0, 16'd1};
  end

  int         cnt;
  logic [7:0] last;

  initial begin
    idle();
    reset = 1'b0;
    #1;
    chk("reset_txv",   u_if.host_tx_valid, 1'b0);
    chk("reset_txch",  u_if.host_tx_ch, 8'h00);
    chk("reset_rxrdy", u_if.host_rx_ready, 1'b1);
    chk("reset_inch",  u_if.uart_in_ch, 8'hFF);
    chk("reset_drop",  u_if.tx_drop_cnt, 16'd0);
    chk("reset_empty", u_if.rx_empty_cnt, 16'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Table: "Hi" through TX, then two host chars read back plus one empty read.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      u_if.uart_out_valid = vec[i].out_v;
      u_if.uart_out_ch    = vec[i].out_ch;
      u_if.uart_in_valid  = vec[i].in_v;
      u_if.host_tx_ready  = vec[i].tx_rdy;
      u_if.host_rx_valid  = vec[i].rx_v;
      u_if.host_rx_ch     = vec[i].rx_ch;
      #1;
      if (vec[i].chk_tx) begin
        chk($sformatf("v%0d_txv", i),  u_if.host_tx_valid, vec[i].e_txv);
        chk($sformatf("v%0d_txch", i), u_if.host_tx_ch, vec[i].e_txch);
        chk($sformatf("v%0d_drop", i), u_if.tx_drop_cnt, vec[i].e_drop);
      end
      chk($sformatf("v%0d_rxrdy", i), u_if.host_rx_ready, vec[i].e_rxrdy);
      chk($sformatf("v%0d_inch", i),  u_if.uart_in_ch, vec[i].e_inch);
      chk($sformatf("v%0d_empty", i), u_if.rx_empty_cnt, vec[i].e_empty);
    end

    // TX overflow: 17 pushes with host stalled, then drain 16 in order.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      u_if.uart_out_valid = 1'b1;
      u_if.uart_out_ch    = 8'h10 + 8'(i);
    end
    @(negedge clock);
    idle();
    #1;
    chk("ovf_drop", u_if.tx_drop_cnt, 16'd1);
    chk("ovf_head", u_if.host_tx_ch, 8'h10);
    @(negedge clock);
    chk("ovf_hold", u_if.host_tx_ch, 8'h10);
    u_if.host_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("drain%0d", i), u_if.host_tx_ch, 8'h10 + 8'(i));
      @(negedge clock);
    end
    #1;
    chk("drain_done", u_if.host_tx_valid, 1'b0);

    // TX full with simultaneous push and pop: push accepted, no drop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      u_if.uart_out_valid = 1'b1;
      u_if.uart_out_ch    = 8'h20 + 8'(i);
    end
    @(negedge clock);
    u_if.uart_out_ch   = 8'hAA;
    u_if.host_tx_ready = 1'b1;
    #1;
    chk("pp_head", u_if.host_tx_ch, 8'h20);
    @(negedge clock);
    u_if.uart_out_valid = 1'b0;
    #1;
    chk("pp_drop", u_if.tx_drop_cnt, 16'd0);
    cnt  = 0;
    last = 8'h00;
    for (int i = 0; i < 40 && u_if.host_tx_valid; i++) begin
      last = u_if.host_tx_ch;
      cnt++;
      @(negedge clock);
      #1;
    end
    chk("pp_occupancy", cnt, 16);
    chk("pp_last", last, 8'hAA);

    // TX push into empty with ready already high: appears next cycle.
    do_reset();
    @(negedge clock);
    u_if.uart_out_valid = 1'b1;
    u_if.uart_out_ch    = 8'h33;
    u_if.host_tx_ready  = 1'b1;
    #1;
    chk("pe_txv_pre", u_if.host_tx_valid, 1'b0);
    @(negedge clock);
    idle();
    #1;
    chk("pe_txv", u_if.host_tx_valid, 1'b1);
    chk("pe_txch", u_if.host_tx_ch, 8'h33);

    // RX full: ready drops, a push during a pop is ignored.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      u_if.host_rx_valid = 1'b1;
      u_if.host_rx_ch    = 8'h50 + 8'(i);
    end
    @(negedge clock);
    u_if.host_rx_ch    = 8'h99;
    u_if.uart_in_valid = 1'b1;
    #1;
    chk("rxf_ready", u_if.host_rx_ready, 1'b0);
    chk("rxf_head", u_if.uart_in_ch, 8'h50);
    @(negedge clock);
    u_if.host_rx_valid = 1'b0;
    #1;
    chk("rxf_ready2", u_if.host_rx_ready, 1'b1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("rxf_rd%0d", i), u_if.uart_in_ch, 8'h50 + 8'(i));
      @(negedge clock);
      #1;
    end
    chk("rxf_nodup", u_if.uart_in_ch, 8'hFF);

    // Host push and core read together on empty RX: no bypass.
    do_reset();
    @(negedge clock);
    u_if.host_rx_valid = 1'b1;
    u_if.host_rx_ch    = 8'h77;
    u_if.uart_in_valid = 1'b1;
    #1;
    chk("nb_inch", u_if.uart_in_ch, 8'hFF);
    @(negedge clock);
    u_if.host_rx_valid = 1'b0;
    #1;
    chk("nb_empty", u_if.rx_empty_cnt, 16'd1);
    chk("nb_next", u_if.uart_in_ch, 8'h77);

`ifdef UART_CONSOLE_ECHO_EN
    // Echo: a core read of 'a' shows up on the host TX side next cycle.
    do_reset();
    @(negedge clock);
    u_if.host_rx_valid = 1'b1;
    u_if.host_rx_ch    = 8'h61;
    @(negedge clock);
    u_if.host_rx_valid = 1'b0;
    u_if.uart_in_valid = 1'b1;
    #1;
    chk("echo_inch", u_if.uart_in_ch, 8'h61);
    @(negedge clock);
    u_if.uart_in_valid = 1'b0;
    #1;
    chk("echo_txv", u_if.host_tx_valid, 1'b1);
    chk("echo_txch", u_if.host_tx_ch, 8'h61);
`endif

    // Reset asserted mid-cycle with both FIFOs loaded clears everything at once.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      u_if.uart_out_valid = 1'b1;
      u_if.uart_out_ch    = 8'h70 + 8'(i);
      u_if.host_rx_valid  = 1'b1;
      u_if.host_rx_ch     = 8'h80 + 8'(i);
    end
    @(negedge clock);
    idle();
    u_if.uart_out_valid = 1'b1;
    u_if.uart_out_ch    = 8'h7F;
    @(negedge clock);
    idle();
    u_if.uart_in_valid = 1'b1;
    #1;
    chk("mr_pre_drop", u_if.tx_drop_cnt, 16'd0);
    chk("mr_pre_inch", u_if.uart_in_ch, 8'h80);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_txv", u_if.host_tx_valid, 1'b0);
    chk("mr_txch", u_if.host_tx_ch, 8'h00);
    chk("mr_rxrdy", u_if.host_rx_ready, 1'b1);
    chk("mr_inch", u_if.uart_in_ch, 8'hFF);
    chk("mr_empty", u_if.rx_empty_cnt, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    u_if.uart_in_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("mr_post_txv", u_if.host_tx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
